// File: rtl/k007232_bus_writer_if.sv
// Request handshake and K007232 CPU-bus pins of the bus writer.
// slave = the writer block itself, master = the CPU glue / bench that feeds it.
interface k007232_bus_writer_if;
    logic       i_REQ_VALID;
    logic       o_REQ_READY;
    logic [3:0] i_REQ_ADDR;
    logic [7:0] i_REQ_DATA;
    logic       o_BUSY;
    logic       o_DACS_n;
    logic       o_WR_n;
    logic [3:0] o_AB;
    logic [7:0] o_DB;
    logic       o_DB_OE;

    modport slave (
        input  i_REQ_VALID, i_REQ_ADDR, i_REQ_DATA,
        output o_REQ_READY, o_BUSY, o_DACS_n, o_WR_n, o_AB, o_DB, o_DB_OE
    );

    modport master (
        output i_REQ_VALID, i_REQ_ADDR, i_REQ_DATA,
        input  o_REQ_READY, o_BUSY, o_DACS_n, o_WR_n, o_AB, o_DB, o_DB_OE
    );
endinterface

// File: rtl/k007232_bus_writer.sv
// Queued register-write initiator for the K007232 CPU bus, edges placed on phiM enables.
// Optional K007232_BUSW_SHADOW_EN adds a readable 16x8 copy of every register written.
module k007232_bus_writer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic                       i_EMUCLK,
    input  logic                       i_RST_n,
    input  logic                       i_PCEN,
    input  logic                       i_NCEN,
    k007232_bus_writer_if.slave        bus
`ifdef K007232_BUSW_SHADOW_EN
    ,
    input  logic [3:0]                 i_SHADOW_ADDR,
    output logic [7:0]                 o_SHADOW_Q
`endif
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [7:0]  GAP_L = 8'(GAP);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CS    = 3'd1,
        DAT   = 3'd2,
        WRL   = 3'd3,
        HOLD  = 3'd4,
        REL   = 3'd5,
        FLT   = 3'd6,
        GAP_W = 3'd7
    } state_t;

    state_t        state_r;
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [AW:0]   wr_ptr_nxt_s;
    logic [AW:0]   rd_ptr_nxt_s;
    logic [11:0]   mem_r [DEPTH];
    logic [11:0]   head_s;
    logic          pcen_s;
    logic          ncen_s;
    logic          push_s;
    logic          pop_s;
    logic          empty_s;
    logic          full_nxt_s;
    logic          idle_nxt_s;
    logic          ready_r;
    logic          busy_r;
    logic          dacs_n_r;
    logic          wr_n_r;
    logic          db_oe_r;
    logic [3:0]    ab_r;
    logic [7:0]    db_r;
    logic [7:0]    data_r;
    logic [7:0]    gap_cnt_r;

    // Strobe qualification, FIFO next-pointer math and next-state idle prediction
    always_comb begin
        pcen_s       = i_PCEN;
        ncen_s       = i_NCEN & ~i_PCEN;
        empty_s      = (wr_ptr_r == rd_ptr_r);
        head_s       = mem_r[rd_ptr_r[AW-1:0]];
        push_s       = bus.i_REQ_VALID & ready_r;
        pop_s        = (state_r == IDLE) & pcen_s & ~empty_s;
        wr_ptr_nxt_s = push_s ? (wr_ptr_r + {{AW{1'b0}}, 1'b1}) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s  ? (rd_ptr_r + {{AW{1'b0}}, 1'b1}) : rd_ptr_r;
        full_nxt_s   = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                       (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
        // busy must fall on the very edge that returns the FSM to IDLE
        case (state_r)
            IDLE:    idle_nxt_s = ~pop_s;
            FLT:     idle_nxt_s = pcen_s & (GAP_L == 8'd0);
            GAP_W:   idle_nxt_s = pcen_s & (gap_cnt_r <= 8'd1);
            default: idle_nxt_s = 1'b0;
        endcase
    end

    // Request FIFO storage
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= 12'd0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {bus.i_REQ_ADDR, bus.i_REQ_DATA};
        end
    end

    // FIFO pointers plus registered ready/busy flags
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            ready_r  <= ~full_nxt_s;
            busy_r   <= (wr_ptr_nxt_s != rd_ptr_nxt_s) | ~idle_nxt_s;
        end
    end

    // Bus sequencer: each state advances only on its own phiM strobe
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_r   <= IDLE;
            dacs_n_r  <= 1'b1;
            wr_n_r    <= 1'b1;
            db_oe_r   <= 1'b0;
            ab_r      <= 4'd0;
            db_r      <= 8'd0;
            data_r    <= 8'd0;
            gap_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        ab_r    <= head_s[11:8];
                        data_r  <= head_s[7:0];
                        state_r <= CS;
                    end
                end
                CS: begin
                    if (ncen_s) begin
                        dacs_n_r <= 1'b0;
                        state_r  <= DAT;
                    end
                end
                DAT: begin
                    if (pcen_s) begin
                        db_r    <= data_r;
                        db_oe_r <= 1'b1;
                        state_r <= WRL;
                    end
                end
                WRL: begin
                    if (ncen_s) begin
                        wr_n_r  <= 1'b0;
                        state_r <= HOLD;
                    end
                end
                HOLD: begin
                    if (pcen_s) begin
                        state_r <= REL;
                    end
                end
                REL: begin
                    if (ncen_s) begin
                        wr_n_r   <= 1'b1;
                        dacs_n_r <= 1'b1;
                        state_r  <= FLT;
                    end
                end
                FLT: begin
                    if (pcen_s) begin
                        db_oe_r   <= 1'b0;
                        db_r      <= 8'd0;
                        gap_cnt_r <= GAP_L;
                        state_r   <= (GAP_L == 8'd0) ? IDLE : GAP_W;
                    end
                end
                GAP_W: begin
                    if (pcen_s) begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                        if (gap_cnt_r <= 8'd1) begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    dacs_n_r <= 1'b1;
                    wr_n_r   <= 1'b1;
                    db_oe_r  <= 1'b0;
                    db_r     <= 8'd0;
                end
            endcase
        end
    end

`ifdef K007232_BUSW_SHADOW_EN
    logic [7:0] shadow_r [16];

    // Shadow copy captured on the same strobe that pulls WR_n low
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            for (int i = 0; i < 16; i++) begin
                shadow_r[i] <= 8'd0;
            end
        end else if ((state_r == WRL) && ncen_s) begin
            shadow_r[ab_r] <= data_r;
        end
    end

    assign o_SHADOW_Q = shadow_r[i_SHADOW_ADDR];
`endif

    assign bus.o_REQ_READY = ready_r;
    assign bus.o_BUSY      = busy_r;
    assign bus.o_DACS_n    = dacs_n_r;
    assign bus.o_WR_n      = wr_n_r;
    assign bus.o_AB        = ab_r;
    assign bus.o_DB        = db_r;
    assign bus.o_DB_OE     = db_oe_r;

endmodule

// File: tb/tb_k007232_bus_writer.sv
// Directed bench for k007232_bus_writer: GAP=1 main instance plus GAP=0 and GAP=3 instances.
module tb_k007232_bus_writer;

    logic clk = 1'b0;
    logic rst_n;
    logic pcen;
    logic ncen;

    always #5 clk = ~clk;

    k007232_bus_writer_if bif ();
    k007232_bus_writer_if bif0 ();
    k007232_bus_writer_if bif3 ();

`ifdef K007232_BUSW_SHADOW_EN
    logic [3:0] sh_addr;
    logic [7:0] sh_q;
    logic [7:0] sh_q0;
    logic [7:0] sh_q3;
`endif

    k007232_bus_writer #(.DEPTH(4), .GAP(1)) dut (
        .i_EMUCLK(clk), .i_RST_n(rst_n), .i_PCEN(pcen), .i_NCEN(ncen), .bus(bif)
`ifdef K007232_BUSW_SHADOW_EN
        , .i_SHADOW_ADDR(sh_addr), .o_SHADOW_Q(sh_q)
`endif
    );

    k007232_bus_writer #(.DEPTH(4), .GAP(0)) dut_g0 (
        .i_EMUCLK(clk), .i_RST_n(rst_n), .i_PCEN(pcen), .i_NCEN(ncen), .bus(bif0)
`ifdef K007232_BUSW_SHADOW_EN
        , .i_SHADOW_ADDR(sh_addr), .o_SHADOW_Q(sh_q0)
`endif
    );

    k007232_bus_writer #(.DEPTH(4), .GAP(3)) dut_g3 (
        .i_EMUCLK(clk), .i_RST_n(rst_n), .i_PCEN(pcen), .i_NCEN(ncen), .bus(bif3)
`ifdef K007232_BUSW_SHADOW_EN
        , .i_SHADOW_ADDR(sh_addr), .o_SHADOW_Q(sh_q3)
`endif
    );

    localparam logic [11:0] EXP_W [13] = '{
        12'hC03, 12'h00F, 12'h1EA, 12'h500, 12'h200, 12'h300, 12'h4FF,
        12'h60F, 12'h7F1, 12'hB00, 12'h800, 12'h9F5, 12'hAFF
    };

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int phase   = 0;
    bit auto_en = 1'b0;
    bit man_p   = 1'b0;
    bit man_n   = 1'b0;
    bit last_p  = 1'b0;
    bit last_n  = 1'b0;
    logic prev_d, prev_d0, prev_d3, prev_wr;
    int fall_q[$];
    int fall_g0_q[$];
    int fall_g3_q[$];
    logic [11:0] wr_q[$];

    // One EMUCLK cycle: strobes applied at negedge, outputs sampled 1ns after posedge
    task automatic cyc();
        @(negedge clk);
        if (auto_en) begin
            pcen  = (phase == 0);
            ncen  = (phase == 2);
            phase = (phase + 1) % 4;
        end else begin
            pcen = man_p;
            ncen = man_n;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        last_p = pcen;
        last_n = ncen;
        if (prev_d  === 1'b1 && bif.o_DACS_n  === 1'b0) fall_q.push_back(cyc_n);
        if (prev_d0 === 1'b1 && bif0.o_DACS_n === 1'b0) fall_g0_q.push_back(cyc_n);
        if (prev_d3 === 1'b1 && bif3.o_DACS_n === 1'b0) fall_g3_q.push_back(cyc_n);
        if (prev_wr === 1'b1 && bif.o_WR_n === 1'b0) wr_q.push_back({bif.o_AB, bif.o_DB});
        prev_d  = bif.o_DACS_n;
        prev_d0 = bif0.o_DACS_n;
        prev_d3 = bif3.o_DACS_n;
        prev_wr = bif.o_WR_n;
    endtask

    task automatic step_p();
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (last_p) break;
        end
    endtask

    task automatic step_n();
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (last_n && !last_p) break;
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (bif.o_BUSY === 1'b0 && bif0.o_BUSY === 1'b0 && bif3.o_BUSY === 1'b0) break;
            cyc();
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        logic r;
        bit   ok = 1'b0;
        bif.i_REQ_VALID = 1'b1;
        bif.i_REQ_ADDR  = a;
        bif.i_REQ_DATA  = d;
        for (int i = 0; i < 400; i++) begin
            r = bif.o_REQ_READY;
            cyc();
            if (r === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        bif.i_REQ_VALID = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: addr %h never accepted", a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        n_tests += 7;
        if (bif.o_DACS_n !== 1'b1) begin n_fail++; $display("FAIL rst_dacs: got %b want 1", bif.o_DACS_n); end
        if (bif.o_WR_n !== 1'b1) begin n_fail++; $display("FAIL rst_wr: got %b want 1", bif.o_WR_n); end
        if (bif.o_AB !== 4'h0) begin n_fail++; $display("FAIL rst_ab: got %h want 0", bif.o_AB); end
        if (bif.o_DB !== 8'h00) begin n_fail++; $display("FAIL rst_db: got %h want 00", bif.o_DB); end
        if (bif.o_DB_OE !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", bif.o_DB_OE); end
        if (bif.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bif.o_BUSY); end
        if (bif.o_REQ_READY !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bif.o_REQ_READY); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        auto_en = 1'b1;
        wr_q.delete();
        push(4'hC, 8'h03);
        n_tests += 2;
        if (bif.o_AB !== 4'h0) begin n_fail++; $display("FAIL single_nopop: ab got %h want 0", bif.o_AB); end
        if (bif.o_BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy_push: got %b want 1", bif.o_BUSY); end
        step_p();
        n_tests += 2;
        if (bif.o_AB !== 4'hC) begin n_fail++; $display("FAIL single_ab_pcen0: got %h want C", bif.o_AB); end
        if (bif.o_DACS_n !== 1'b1) begin n_fail++; $display("FAIL single_dacs_pcen0: got %b want 1", bif.o_DACS_n); end
        step_n();
        n_tests += 2;
        if (bif.o_DACS_n !== 1'b0) begin n_fail++; $display("FAIL single_dacs_ncen0: got %b want 0", bif.o_DACS_n); end
        if (bif.o_DB_OE !== 1'b0) begin n_fail++; $display("FAIL single_oe_ncen0: got %b want 0", bif.o_DB_OE); end
        step_p();
        n_tests += 3;
        if (bif.o_DB !== 8'h03) begin n_fail++; $display("FAIL single_db_pcen1: got %h want 03", bif.o_DB); end
        if (bif.o_DB_OE !== 1'b1) begin n_fail++; $display("FAIL single_oe_pcen1: got %b want 1", bif.o_DB_OE); end
        if (bif.o_WR_n !== 1'b1) begin n_fail++; $display("FAIL single_wr_pcen1: got %b want 1", bif.o_WR_n); end
        step_n();
        n_tests++;
        if (bif.o_WR_n !== 1'b0) begin n_fail++; $display("FAIL single_wr_ncen1: got %b want 0", bif.o_WR_n); end
        step_p();
        n_tests++;
        if (bif.o_WR_n !== 1'b0) begin n_fail++; $display("FAIL single_wr_pcen2: got %b want 0", bif.o_WR_n); end
        step_n();
        n_tests += 3;
        if (bif.o_WR_n !== 1'b1) begin n_fail++; $display("FAIL single_wr_ncen2: got %b want 1", bif.o_WR_n); end
        if (bif.o_DACS_n !== 1'b1) begin n_fail++; $display("FAIL single_dacs_ncen2: got %b want 1", bif.o_DACS_n); end
        if (bif.o_DB_OE !== 1'b1) begin n_fail++; $display("FAIL single_oe_ncen2: got %b want 1", bif.o_DB_OE); end
        step_p();
        n_tests += 3;
        if (bif.o_DB_OE !== 1'b0) begin n_fail++; $display("FAIL single_oe_pcen3: got %b want 0", bif.o_DB_OE); end
        if (bif.o_DB !== 8'h00) begin n_fail++; $display("FAIL single_db_pcen3: got %h want 00", bif.o_DB); end
        if (bif.o_BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy_pcen3: got %b want 1", bif.o_BUSY); end
        step_p();
        n_tests += 3;
        if (bif.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL single_busy_pcen4: got %b want 0", bif.o_BUSY); end
        if (bif.o_AB !== 4'hC) begin n_fail++; $display("FAIL single_ab_hold: got %h want C", bif.o_AB); end
        if (wr_q.size() != 1) begin n_fail++; $display("FAIL single_wr_count: got %0d want 1", wr_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] w;
        int n;
        auto_en = 1'b0;
        man_p = 1'b0;
        man_n = 1'b0;
        wr_q.delete();
        fall_q.delete();
        for (int i = 0; i < 4; i++) begin
            w = EXP_W[i];
            push(w[11:8], w[7:0]);
        end
        n_tests += 2;
        if (bif.o_REQ_READY !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", bif.o_REQ_READY); end
        if (bif.o_BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_full: got %b want 1", bif.o_BUSY); end
        w = EXP_W[4];
        bif.i_REQ_VALID = 1'b1;
        bif.i_REQ_ADDR  = w[11:8];
        bif.i_REQ_DATA  = w[7:0];
        repeat (3) cyc();
        n_tests++;
        if (bif.o_REQ_READY !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_frozen: got %b want 0", bif.o_REQ_READY); end
        phase = 0;
        auto_en = 1'b1;
        for (int i = 4; i < 13; i++) begin
            w = EXP_W[i];
            push(w[11:8], w[7:0]);
        end
        for (int i = 0; i < 800; i++) begin
            if (wr_q.size() >= 13) break;
            cyc();
        end
        wait_idle(200);
        n = wr_q.size();
        n_tests += 2;
        if (n != 13) begin n_fail++; $display("FAIL b2b_wr_count: got %0d want 13", n); end
        if (fall_q.size() != 13) begin n_fail++; $display("FAIL b2b_cs_count: got %0d want 13", fall_q.size()); end
        for (int i = 0; i < 13; i++) begin
            n_tests++;
            w = (i < n) ? wr_q[i] : 12'hXXX;
            if (w !== EXP_W[i]) begin n_fail++; $display("FAIL b2b_write_%0d: got %h want %h", i, w, EXP_W[i]); end
        end
        for (int i = 1; i < fall_q.size(); i++) begin
            n_tests++;
            if (fall_q[i] - fall_q[i-1] != 20) begin
                n_fail++;
                $display("FAIL b2b_spacing_%0d: got %0d clocks want 20", i, fall_q[i] - fall_q[i-1]);
            end
        end
    endtask

    task automatic test_gap();
        int d0;
        int d3;
        auto_en = 1'b0;
        man_p = 1'b0;
        man_n = 1'b0;
        fall_g0_q.delete();
        fall_g3_q.delete();
        bif0.i_REQ_VALID = 1'b1;
        bif3.i_REQ_VALID = 1'b1;
        bif0.i_REQ_ADDR = 4'h1; bif0.i_REQ_DATA = 8'h11;
        bif3.i_REQ_ADDR = 4'h1; bif3.i_REQ_DATA = 8'h11;
        cyc();
        bif0.i_REQ_ADDR = 4'h2; bif0.i_REQ_DATA = 8'h22;
        bif3.i_REQ_ADDR = 4'h2; bif3.i_REQ_DATA = 8'h22;
        cyc();
        bif0.i_REQ_VALID = 1'b0;
        bif3.i_REQ_VALID = 1'b0;
        phase = 0;
        auto_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (fall_g0_q.size() >= 2 && fall_g3_q.size() >= 2) break;
            cyc();
        end
        wait_idle(200);
        d0 = (fall_g0_q.size() >= 2) ? fall_g0_q[1] - fall_g0_q[0] : -1;
        d3 = (fall_g3_q.size() >= 2) ? fall_g3_q[1] - fall_g3_q[0] : -1;
        n_tests += 2;
        if (d0 != 16) begin n_fail++; $display("FAIL gap0_spacing: got %0d clocks want 16", d0); end
        if (d3 != 28) begin n_fail++; $display("FAIL gap3_spacing: got %0d clocks want 28", d3); end
    endtask

    task automatic test_reset_mid();
        auto_en = 1'b0;
        man_p = 1'b0;
        man_n = 1'b0;
        push(4'hA, 8'h11);
        push(4'hB, 8'h22);
        push(4'hD, 8'h33);
        phase = 0;
        auto_en = 1'b1;
        step_p();
        step_n();
        step_p();
        n_tests++;
        if (bif.o_DB_OE !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_oe: got %b want 1", bif.o_DB_OE); end
        rst_n = 1'b0;
        #1;
        n_tests += 5;
        if (bif.o_DACS_n !== 1'b1) begin n_fail++; $display("FAIL rmid_dacs: got %b want 1", bif.o_DACS_n); end
        if (bif.o_WR_n !== 1'b1) begin n_fail++; $display("FAIL rmid_wr: got %b want 1", bif.o_WR_n); end
        if (bif.o_DB_OE !== 1'b0) begin n_fail++; $display("FAIL rmid_oe: got %b want 0", bif.o_DB_OE); end
        if (bif.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", bif.o_BUSY); end
        if (bif.o_REQ_READY !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", bif.o_REQ_READY); end
        repeat (2) cyc();
        rst_n = 1'b1;
        fall_q.delete();
        repeat (150) cyc();
        n_tests += 2;
        if (fall_q.size() != 0) begin n_fail++; $display("FAIL rmid_stale_cs: got %0d falls want 0", fall_q.size()); end
        if (bif.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_after: got %b want 0", bif.o_BUSY); end
    endtask

    task automatic test_simul_strobe();
        auto_en = 1'b0;
        man_p = 1'b0;
        man_n = 1'b0;
        push(4'h5, 8'h5A);
        man_p = 1'b1;
        cyc();
        man_n = 1'b1;
        cyc();
        n_tests++;
        if (bif.o_DACS_n !== 1'b1) begin n_fail++; $display("FAIL simul_ncen_ignored: got %b want 1", bif.o_DACS_n); end
        man_p = 1'b0;
        man_n = 1'b0;
        cyc();
        man_n = 1'b1;
        cyc();
        n_tests++;
        if (bif.o_DACS_n !== 1'b0) begin n_fail++; $display("FAIL simul_lone_ncen: got %b want 0", bif.o_DACS_n); end
        man_n = 1'b0;
        phase = 0;
        auto_en = 1'b1;
        wait_idle(200);
    endtask

`ifdef K007232_BUSW_SHADOW_EN
    task automatic test_shadow();
        sh_addr = 4'h9;
        auto_en = 1'b1;
        #1;
        n_tests++;
        if (sh_q !== 8'h00) begin n_fail++; $display("FAIL shadow_init: got %h want 00", sh_q); end
        push(4'h9, 8'hF5);
        step_p(); step_n(); step_p();
        n_tests++;
        if (sh_q !== 8'h00) begin n_fail++; $display("FAIL shadow_early: got %h want 00", sh_q); end
        step_n();
        n_tests++;
        if (sh_q !== 8'hF5) begin n_fail++; $display("FAIL shadow_first: got %h want F5", sh_q); end
        wait_idle(200);
        push(4'h9, 8'hA0);
        step_p(); step_n(); step_p(); step_n();
        n_tests++;
        if (sh_q !== 8'hA0) begin n_fail++; $display("FAIL shadow_second: got %h want A0", sh_q); end
        sh_addr = 4'h8;
        #1;
        n_tests++;
        if (sh_q !== 8'h00) begin n_fail++; $display("FAIL shadow_other: got %h want 00", sh_q); end
        wait_idle(200);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        pcen = 1'b0;
        ncen = 1'b0;
        prev_d = 1'b1; prev_d0 = 1'b1; prev_d3 = 1'b1; prev_wr = 1'b1;
        bif.i_REQ_VALID  = 1'b0; bif.i_REQ_ADDR  = 4'h0; bif.i_REQ_DATA  = 8'h00;
        bif0.i_REQ_VALID = 1'b0; bif0.i_REQ_ADDR = 4'h0; bif0.i_REQ_DATA = 8'h00;
        bif3.i_REQ_VALID = 1'b0; bif3.i_REQ_ADDR = 4'h0; bif3.i_REQ_DATA = 8'h00;
`ifdef K007232_BUSW_SHADOW_EN
        sh_addr = 4'h0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_simul_strobe();
`ifdef K007232_BUSW_SHADOW_EN
        test_shadow();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
